cmos_cfg_sequencer: RTL
=======================

// Module: cmos_cfg_sequencer
// PURPOSE
//  Walks the camera register LUT (index -> {reg_addr, reg_data}) and issues each entry to the SCCB master.
//  Applies the power-up wait and the post-soft-reset wait, retries NACKed transfers and verifies ID reads.
//  Sits between the LUT ROM and the SCCB master; drives cfg_done, which releases the CMOS capture path.
// PARAMETERS
//  POWERUP_CYCLES  25_000  clk cycles waited after reset before the first transfer (1 ms @ 25 MHz)
//  SWRST_CYCLES    25_000  clk cycles waited after a write of reg 0x12 with data bit7=1 (soft reset)
//  READ_NUM        2       leading LUT entries that are reads; the data byte is the expected read value
//  RETRY_MAX       3       retries per entry after a NACK; on exhausting them the block enters FAIL
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  cfg_restart  in   1   1-cycle pulse: rerun the table; honoured only in DONE or FAIL
//  lut_index    out  8   registered LUT address
//  lut_data     in   16  {reg_addr[15:8], reg_data[7:0]}, combinational from lut_index
//  lut_size     in   8   number of LUT entries
//  cmd_valid    out  1   command request to the SCCB master
//  cmd_ready    in   1   master accepts the command when cmd_valid && cmd_ready
//  cmd_rd       out  1   1=read, 0=write
//  cmd_addr     out  8   register address
//  cmd_wdata    out  8   write data
//  rsp_done     in   1   1-cycle pulse: transfer finished
//  rsp_nack     in   1   valid with rsp_done: slave NACKed
//  rsp_rdata    in   8   valid with rsp_done when cmd_rd=1
//  cfg_busy     out  1   sequence in progress
//  cfg_done     out  1   whole table written and verified; sticky until restart or rst
//  cfg_err      out  1   entered FAIL; sticky until restart or rst
//  err_index    out  8   index of the failing entry, valid while cfg_err=1
// BEHAVIOUR
//  Reset: state=PWRUP, lut_index=FIRST, cmd_valid=0, cmd_rd=0, cmd_addr=0, cmd_wdata=0, cfg_busy=1,
//   cfg_done=0, cfg_err=0, err_index=0, retry count=0, wait counter=0. FIRST is 0 or READ_NUM (see CONFIGURATION).
//  States:
//  - PWRUP: count POWERUP_CYCLES, then go to LOAD. If lut_size<=FIRST, go straight to DONE.
//  - LOAD (1 cycle): latch lut_data into cmd_addr/cmd_wdata; cmd_rd=(lut_index<READ_NUM); go to ISSUE.
//  - ISSUE: cmd_valid=1, fields held stable; on cmd_ready, cmd_valid drops the next cycle and state -> WAIT.
//  - WAIT: on rsp_done:
//    - nack with retry<RETRY_MAX: retry++, go to LOAD for the same index.
//    - nack with retry==RETRY_MAX: go to FAIL.
//    - read whose rsp_rdata!=cmd_wdata: go to FAIL.
//    - write to reg 0x12 with wdata[7]=1: go to SWRST.
//    - otherwise: go to NEXT.
//  - SWRST: count SWRST_CYCLES, then go to NEXT.
//  - NEXT: retry=0; if lut_index==lut_size-1, go to DONE; else lut_index++ and go to LOAD.
//  - DONE: cfg_busy=0, cfg_done=1.
//  - FAIL: cfg_busy=0, cfg_err=1, err_index=lut_index.
//  Restart: cfg_restart in DONE/FAIL -> lut_index=FIRST, flags cleared, busy=1, state=LOAD (no power-up wait).
//   Ignored in all other states.
//  Timing/handshake: at most one outstanding command. rsp_done outside WAIT is ignored.
//   Latency from entry accept to the next cmd_valid is 2 cycles (NEXT, LOAD) plus any SWRST wait.
//  Widths/counters: lut_index compare is 8-bit and never wraps; the max table is 255 entries.
//   Wait counters are 32-bit and count 0..N-1.
//  rst mid-transfer: cmd_valid drops the next cycle. The SCCB master is reset by the same rst.
// CONFIGURATION
//  CMOS_CFG_ID_CHECK_EN defined: FIRST=0; entries 0..READ_NUM-1 are read and compared, and a mismatch gives FAIL.
//  Not defined: FIRST=READ_NUM; read entries are never issued, lut_index starts at READ_NUM,
//   and the only FAIL cause is NACK exhaustion.
// TESTING  (POWERUP_CYCLES=100, SWRST_CYCLES=50, lut_size=70, ID_CHECK_EN defined, model acks in 10 cycles)
//  - Reset release -> no cmd_valid for 100 cycles; then read addr 0x1C; rdata 0x7F, then 0x1D/0xA2 ->
//    70 transfers in index order; cfg_done=1, cfg_busy=0.
//  - Index 2 write {0x12,0x80} -> the next cmd_valid appears >=50 cycles after its rsp_done.
//  - Read 0x1C returns 0x7E -> cfg_err=1, err_index=0, no further cmd_valid.
//  - NACK index 5 three times, then ACK -> 4 issues of {0x17,0x22}; sequence completes with cfg_done=1.
//    NACK 4 times -> FAIL with err_index=5.
//  - cmd_ready held low 20 cycles -> cmd_valid and fields stay stable throughout; exactly one accept.
//  - cfg_restart in DONE -> rerun from index 0 with no power-up wait; restart pulse while busy -> ignored.
//    Macro undefined -> the first command is write {0x12,0x80}.

Source files
------------

// File: rtl/cmos_cfg_sequencer.sv
// Walks the camera register LUT and issues each entry to the SCCB master, with power-up and soft-reset waits,
// NACK retries and ID verification reads (ID reads enabled by defining CMOS_CFG_ID_CHECK_EN).
module cmos_cfg_sequencer #(
  parameter int unsigned POWERUP_CYCLES = 25000,
  parameter int unsigned SWRST_CYCLES   = 25000,
  parameter int unsigned READ_NUM       = 2,
  parameter int unsigned RETRY_MAX      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_restart,
  output logic [7:0]  lut_index,
  input  logic [15:0] lut_data,
  input  logic [7:0]  lut_size,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_rd,
  output logic [7:0]  cmd_addr,
  output logic [7:0]  cmd_wdata,
  input  logic        rsp_done,
  input  logic        rsp_nack,
  input  logic [7:0]  rsp_rdata,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [7:0]  err_index
);

`ifdef CMOS_CFG_ID_CHECK_EN
  localparam logic [7:0] FIRST = 8'd0;
`else
  localparam logic [7:0] FIRST = 8'(READ_NUM);
`endif
  localparam logic [7:0]  READ_END  = 8'(READ_NUM);
  localparam logic [7:0]  RETRY_LIM = 8'(RETRY_MAX);
  localparam logic [31:0] PWR_LAST  = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] SWR_LAST  = 32'(SWRST_CYCLES - 1);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_SWRST = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_FAIL  = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [7:0]  lut_index_q, lut_index_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_rd_q, cmd_rd_d;
  logic [7:0]  cmd_addr_q, cmd_addr_d;
  logic [7:0]  cmd_wdata_q, cmd_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  err_index_q, err_index_d;
  logic [7:0]  retry_q, retry_d;
  logic [31:0] wait_q, wait_d;

  always_comb begin
    state_d     = state_q;
    lut_index_d = lut_index_q;
    cmd_valid_d = cmd_valid_q;
    cmd_rd_d    = cmd_rd_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    err_index_d = err_index_q;
    retry_d     = retry_q;
    wait_d      = wait_q;
    case (state_q)
      S_PWRUP: begin
        if (wait_q == PWR_LAST) begin
          wait_d = '0;
          if (lut_size <= FIRST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_LOAD: begin
        cmd_addr_d  = lut_data[15:8];
        cmd_wdata_d = lut_data[7:0];
        cmd_rd_d    = (lut_index_q < READ_END);
        cmd_valid_d = 1'b1;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_done) begin
          // For reads the LUT data byte holds the expected ID value.
          if (rsp_nack && (retry_q < RETRY_LIM)) begin
            retry_d = retry_q + 8'd1;
            state_d = S_LOAD;
          end else if (rsp_nack || (cmd_rd_q && (rsp_rdata != cmd_wdata_q))) begin
            state_d     = S_FAIL;
            busy_d      = 1'b0;
            err_d       = 1'b1;
            err_index_d = lut_index_q;
          end else if (!cmd_rd_q && (cmd_addr_q == 8'h12) && cmd_wdata_q[7]) begin
            state_d = S_SWRST;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_SWRST: begin
        if (wait_q == SWR_LAST) begin
          wait_d  = '0;
          state_d = S_NEXT;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_NEXT: begin
        retry_d = '0;
        if (lut_index_q == (lut_size - 8'd1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          lut_index_d = lut_index_q + 8'd1;
          state_d     = S_LOAD;
        end
      end
      S_DONE, S_FAIL: begin
        if (cfg_restart) begin
          state_d     = S_LOAD;
          lut_index_d = FIRST;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          err_index_d = '0;
          retry_d     = '0;
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PWRUP;
      lut_index_q <= FIRST;
      cmd_valid_q <= 1'b0;
      cmd_rd_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_index_q <= '0;
      retry_q     <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      lut_index_q <= lut_index_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_index_q <= err_index_d;
      retry_q     <= retry_d;
      wait_q      <= wait_d;
    end
  end

  assign lut_index = lut_index_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_rd    = cmd_rd_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign cfg_busy  = busy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign err_index = err_index_q;

endmodule
